// File: rtl/mac_acc_divider_if.sv
// Request/result bundle for the sequential accumulator divider.
// The master side issues start plus operands; the slave side returns status and results.
interface mac_acc_divider_if #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 8
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/mac_acc_divider.sv
// Sequential restoring divider placed after the MAC accumulator.
// It retires one quotient bit per falling clock edge. The dividend register
// doubles as the quotient shift register: dividend bits leave at the MSB end
// while quotient bits enter at the LSB end. The result outputs are loaded only
// when a division completes, so partial iteration values never reach them.
module mac_acc_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    mac_acc_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [DIVIDEND_W-1:0] dvd_r, dvd_s;          // dividend in, quotient out
    logic [DIVISOR_W-1:0]  dsr_r, dsr_s;          // captured divisor
    logic [DIVISOR_W:0]    rem_r, rem_s;          // partial remainder
    logic [CNT_W-1:0]      cnt_r, cnt_s;          // restoring steps taken
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  dbz_r, dbz_s;
    logic [DIVIDEND_W-1:0] quotient_r, quotient_s;
    logic [DIVISOR_W-1:0]  remainder_r, remainder_s;
    logic [DIVISOR_W+1:0]  trial_s;               // MSB set means the subtraction borrowed

    // Next-state, datapath step and output loading for the divider FSM
    always_comb begin
        state_s     = state_r;
        dvd_s       = dvd_r;
        dsr_s       = dsr_r;
        rem_s       = rem_r;
        cnt_s       = cnt_r;
        busy_s      = busy_r;
        done_s      = done_r;
        dbz_s       = dbz_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        // The partial remainder stays below the divisor, so its top bit is
        // zero and the borrow bit of this subtraction is a reliable sign.
        trial_s     = {rem_r, dvd_r[DIVIDEND_W-1]} - {2'b00, dsr_r};

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != {DIVISOR_W{1'b0}}) begin
                        dvd_s   = bus.dividend;
                        dsr_s   = bus.divisor;
                        rem_s   = {(DIVISOR_W+1){1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                        busy_s  = 1'b1;
                        state_s = ST_RUN;
                    end else begin
                        // A zero divisor finishes immediately with a saturated quotient.
                        quotient_s  = {DIVIDEND_W{1'b1}};
                        remainder_s = {DIVISOR_W{1'b0}};
                        dbz_s       = 1'b1;
                        done_s      = 1'b1;
                        busy_s      = 1'b0;
                        state_s     = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (trial_s[DIVISOR_W+1]) begin
                    rem_s = {rem_r[DIVISOR_W-1:0], dvd_r[DIVIDEND_W-1]};
                    dvd_s = {dvd_r[DIVIDEND_W-2:0], 1'b0};
                end else begin
                    rem_s = trial_s[DIVISOR_W:0];
                    dvd_s = {dvd_r[DIVIDEND_W-2:0], 1'b1};
                end
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(DIVIDEND_W - 1)) begin
                    quotient_s  = dvd_s;
                    remainder_s = rem_s[DIVISOR_W-1:0];
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    dbz_s       = 1'b0;
                    state_s     = ST_FIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN: begin
                // Any start seen on this edge is intentionally dropped.
                done_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                done_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Falling-edge state and datapath registers with asynchronous clear
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            dvd_r       <= {DIVIDEND_W{1'b0}};
            dsr_r       <= {DIVISOR_W{1'b0}};
            rem_r       <= {(DIVISOR_W+1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
        end else begin
            state_r     <= state_s;
            dvd_r       <= dvd_s;
            dsr_r       <= dsr_s;
            rem_r       <= rem_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            dbz_r       <= dbz_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
endmodule

// File: tb/tb_mac_acc_divider.sv
// Directed and randomised bench for the falling-edge accumulator divider.
// Inputs change on the rising edge and outputs are sampled 1 time unit after
// the rising edge, keeping both away from the active falling edge.
module tb_mac_acc_divider;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mac_acc_divider_if #(.DIVIDEND_W(32), .DIVISOR_W(8)) bus ();

    mac_acc_divider #(.DIVIDEND_W(32), .DIVISOR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division and wait (bounded) for done. lat is the index of the
    // rising edge after acceptance where done is first seen (-1 on timeout).
    task automatic run_div(input logic [31:0] a, input logic [7:0] b,
                           output logic [31:0] q, output logic [7:0] r, output logic dz,
                           output int lat, output int busy_cycles, output int done_width);
        @(posedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        bus.start = 1'b0;
        lat = 1; busy_cycles = 0; done_width = 0; q = '0; r = '0; dz = 1'b0;
        #1;
        while (!bus.done && lat < 60) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done) begin
            q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
            done_width = 1;
            @(posedge clk); #1;
            if (bus.done) done_width++;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.dividend = 32'd0; bus.divisor = 8'd0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b dbz=%0b q=%0h r=%0h expected all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(posedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 43'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%0b done=%0b q=%0h expected all 0",
                     bus.busy, bus.done, bus.quotient);
        end
    endtask

    task automatic test_basic();
        logic [31:0] q; logic [7:0] r; logic dz; int lat, bc, dw;
        run_div(32'd1000, 8'd7, q, r, dz, lat, bc, dw);
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL basic_latency: got %0d expected 33", lat); end
        checks++;
        if (bc !== 32) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 32", bc); end
        checks++;
        if (q !== 32'd142) begin failures++; $display("FAIL basic_quotient: got %0d expected 142", q); end
        checks++;
        if (r !== 8'd6) begin failures++; $display("FAIL basic_remainder: got %0d expected 6", r); end
        checks++;
        if (dz !== 1'b0) begin failures++; $display("FAIL basic_dbz: got %0b expected 0", dz); end
        checks++;
        if (dw !== 1) begin failures++; $display("FAIL basic_done_width: got %0d expected 1", dw); end
    endtask

    task automatic test_extremes();
        logic [31:0] a_tab [3] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        logic [7:0]  b_tab [3] = '{8'd1, 8'd255, 8'd255};
        logic [31:0] q_tab [3] = '{32'hFFFF_FFFF, 32'd0, 32'h0101_0101};
        logic [7:0]  r_tab [3] = '{8'd0, 8'd5, 8'd0};
        logic [31:0] q; logic [7:0] r; logic dz; int lat, bc, dw;
        for (int i = 0; i < 3; i++) begin
            run_div(a_tab[i], b_tab[i], q, r, dz, lat, bc, dw);
            checks++;
            if (q !== q_tab[i]) begin failures++; $display("FAIL extreme_quotient[%0d]: got %0h expected %0h", i, q, q_tab[i]); end
            checks++;
            if (r !== r_tab[i]) begin failures++; $display("FAIL extreme_remainder[%0d]: got %0h expected %0h", i, r, r_tab[i]); end
            checks++;
            if (lat !== 33 || dz !== 1'b0) begin failures++; $display("FAIL extreme_done[%0d]: got lat=%0d dbz=%0b expected 33/0", i, lat, dz); end
        end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] q; logic [7:0] r; logic dz; int lat, bc, dw;
        run_div(32'd1234, 8'd0, q, r, dz, lat, bc, dw);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        checks++;
        if (dz !== 1'b1) begin failures++; $display("FAIL dbz_flag: got %0b expected 1", dz); end
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 8'd0) begin failures++; $display("FAIL dbz_result: got q=%0h r=%0h expected ffffffff/0", q, r); end
        checks++;
        if (dw !== 1 || bc !== 0) begin failures++; $display("FAIL dbz_pulse: got width=%0d busy=%0d expected 1/0", dw, bc); end
        run_div(32'd100, 8'd10, q, r, dz, lat, bc, dw);
        checks++;
        if (q !== 32'd10 || r !== 8'd0 || dz !== 1'b0) begin
            failures++; $display("FAIL after_dbz: got q=%0d r=%0d dbz=%0b expected 10/0/0", q, r, dz);
        end
    endtask

    task automatic test_busy_ignore();
        int done_count = 0; int leak = 0;
        logic [31:0] q = '0; logic [7:0] r = '0;
        @(posedge clk);
        bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 8'd7;
        @(posedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) begin bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 8'd5; end
            if (k == 11) bus.start = 1'b0;
            if (k == 20) begin bus.dividend = 32'd12345; bus.divisor = 8'd3; end
            if (k == 33) begin bus.start = 1'b1; bus.dividend = 32'd81; bus.divisor = 8'd9; end
            if (k == 34) bus.start = 1'b0;
            #1;
            if (bus.done) begin done_count++; q = bus.quotient; r = bus.remainder; end
            if (bus.busy && bus.quotient !== 32'd10) leak++;
            @(posedge clk);
        end
        checks++;
        if (done_count !== 1) begin failures++; $display("FAIL busy_done_count: got %0d expected 1", done_count); end
        checks++;
        if (q !== 32'd142 || r !== 8'd6) begin failures++; $display("FAIL busy_result: got q=%0d r=%0d expected 142/6", q, r); end
        checks++;
        if (leak !== 0) begin failures++; $display("FAIL busy_output_hold: got %0d changed cycles expected 0", leak); end
    endtask

    task automatic test_reset_mid_op();
        int stray = 0;
        logic [31:0] q; logic [7:0] r; logic dz; int lat, bc, dw;
        @(posedge clk);
        bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 8'd7;
        @(posedge clk);
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 43'd0) begin
            failures++;
            $display("FAIL midop_reset: got busy=%0b done=%0b q=%0h r=%0h expected all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        repeat (2) @(posedge clk);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL midop_no_done: got %0d active cycles expected 0", stray); end
        run_div(32'd81, 8'd9, q, r, dz, lat, bc, dw);
        checks++;
        if (q !== 32'd9 || r !== 8'd0 || dz !== 1'b0 || lat !== 33) begin
            failures++; $display("FAIL midop_recover: got q=%0d r=%0d dbz=%0b lat=%0d expected 9/0/0/33", q, r, dz, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, q; logic [7:0] b, r; logic dz; int lat, bc, dw;
        logic [63:0] recon;
        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            b = 8'($urandom_range(1, 255));
            run_div(a, b, q, r, dz, lat, bc, dw);
            recon = {32'd0, q} * {56'd0, b} + {56'd0, r};
            checks++;
            if (lat !== 33) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 33", i, lat); end
            checks++;
            if (recon !== {32'd0, a}) begin failures++; $display("FAIL rand_identity[%0d]: %0d/%0d got q=%0d r=%0d", i, a, b, q, r); end
            checks++;
            if (r >= b) begin failures++; $display("FAIL rand_rem_bound[%0d]: got r=%0d expected below %0d", i, r, b); end
            checks++;
            if (dw !== 1 || dz !== 1'b0) begin failures++; $display("FAIL rand_done[%0d]: got width=%0d dbz=%0b expected 1/0", i, dw, dz); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_busy_ignore();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
